beam_scan_scheduler: RTL and testbench
======================================

Name: beam_scan_scheduler

Overview:
Sequences the sonar front end through a beam-angle sweep. Each ping period it:
- drives beam_angle
- emits the burst_start / burst_active window that gates the transmit beamformer
- opens a listen window for the SPI/receive path
- captures the first time-of-flight result, or a no-echo marker, per angle.

It sits between the top-level control and the sin_lut / transmit_beamformer / spi_con / time_of_flight datapath, replacing the free-running pulse_cooldown PWM and the static beam angle.

Parameters:
PERIOD_CYCLES, 16777216, total cycles per ping (burst plus listen); must exceed BURST_CYCLES+1
BURST_CYCLES, 524288, cycles burst_active is high per ping
ANGLE_WIDTH, 8, signed beam angle width in degrees
ANGLE_MIN, -30, first/lowest sweep angle
ANGLE_MAX, 30, highest sweep angle
ANGLE_STEP, 10, positive sweep increment; (ANGLE_MAX-ANGLE_MIN) divisible by it
RANGE_WIDTH, 16, width of range value

Ports:
clk_in  input  1  system clock (100 MHz)
rst_in  input  1  reset, asynchronous, active-low
enable_in  input  1  run sweep; sampled at period boundaries
fixed_mode_in  input  1  1: hold fixed_angle_in instead of sweeping
fixed_angle_in  input  ANGLE_WIDTH  signed fixed angle, clamped to [ANGLE_MIN, ANGLE_MAX]
tof_valid_in  input  1  time_of_flight result strobe
range_in  input  RANGE_WIDTH  time_of_flight range
beam_angle_out  output  ANGLE_WIDTH  signed current angle
burst_start_out  output  1  one-cycle pulse on first burst cycle; also the datapath per-ping reset
burst_active_out  output  1  transmit gate
listen_out  output  1  receive window (ADC trigger enable)
result_valid_out  output  1  one-cycle result strobe
result_angle_out  output  ANGLE_WIDTH  angle the result belongs to
result_range_out  output  RANGE_WIDTH  captured range or NO_ECHO
frame_done_out  output  1  one-cycle pulse when the last angle of a sweep direction completes

Behaviour:
Reset (rst_in low, async):
- state IDLE, cycle counter 0, beam_angle_out=ANGLE_MIN.
- All strobes/gates 0; result_angle_out=0; result_range_out=0.

States and transitions:
- IDLE: outputs quiet. If enable_in=1, next cycle enters BURST with counter=0.
- BURST:
  - burst_active_out=1 for exactly BURST_CYCLES cycles.
  - burst_start_out=1 only on the first cycle.
  - Then LISTEN.
- LISTEN:
  - listen_out=1 for PERIOD_CYCLES-BURST_CYCLES-1 cycles.
  - The first tof_valid_in latches range_in; later strobes are ignored.
  - tof_valid_in in BURST or IDLE is ignored.
  - A strobe on the final LISTEN cycle is accepted.
- ADVANCE (1 cycle):
  - result_valid_out=1, with result_angle_out = current angle and result_range_out = latched range, or NO_ECHO (all ones) if none was latched.
  - Compute the next angle:
    - fixed_mode_in=1: clamped fixed_angle_in.
    - Otherwise angle+ANGLE_STEP; past ANGLE_MAX it wraps to ANGLE_MIN.
    - A sweep angle outside the range (after leaving fixed mode) restarts at ANGLE_MIN.
  - frame_done_out=1 when the completed angle was ANGLE_MAX in sweep mode.
  - Next state: BURST if enable_in=1, else IDLE (angle retained).

Timing and arithmetic:
- Period is exactly PERIOD_CYCLES cycles: BURST + LISTEN + ADVANCE.
- beam_angle_out is stable throughout BURST and LISTEN; it changes only in ADVANCE.
- Deasserting enable_in mid-ping does not truncate the ping.
- Counter width is $clog2(PERIOD_CYCLES); no wrap inside a state.
- Angle arithmetic is signed, ANGLE_WIDTH+1 bits internally before the compare.

Optional Feature:
Macro SCAN_PINGPONG_EN.
- Defined: the sweep reverses direction at ANGLE_MAX and ANGLE_MIN (-30..30..-30) without repeating the endpoint; frame_done_out pulses at each endpoint.
- Undefined: wrap behaviour as above. The direction register is absent.

Decomposition:
Package sonar_scan_pkg holds:
- the state enum (IDLE, BURST, LISTEN, ADVANCE)
- the NO_ECHO constant
- typedef angle_t (signed ANGLE_WIDTH)

A natural sub-module is angle_sequencer. It is combinational next-angle plus the registered angle/direction, and carries the clamp, wrap and ping-pong logic.

Test Plan:
Use PERIOD_CYCLES=100, BURST_CYCLES=20, default angles.
- Reset then enable_in=1 -> burst_start_out pulse 1 cycle later; burst_active_out high 20 cycles; listen_out high 79; result_valid_out at cycle 100; next burst_start_out at cycle 101.
- Sweep with tof_valid_in (range 0x0123) at LISTEN cycle 10 in every ping -> results at angles -30,-20,-10,0,10,20,30, then -30; frame_done_out with the angle-30 result.
- No tof_valid_in; tof_valid_in only during BURST -> result_range_out=0xFFFF.
- Two strobes (0x0050, 0x0090) in one LISTEN -> result 0x0050.
- fixed_mode_in=1, fixed_angle_in=45 -> next angle 30. Drop enable_in mid-LISTEN -> ping completes, then IDLE. Assert rst_in low mid-BURST -> outputs 0 immediately, angle -30.
- With SCAN_PINGPONG_EN -> angle order -30..30, 20, 10..-30; frame_done_out at 30 and -30.

Source files
------------

// File: rtl/sonar_scan_pkg.sv
// Shared types for the sonar beam-scan scheduler: FSM states, angle/range types, no-echo marker.
package sonar_scan_pkg;

  localparam int ANGLE_WIDTH = 8;
  localparam int RANGE_WIDTH = 16;

  typedef logic signed [ANGLE_WIDTH-1:0] angle_t;
  typedef logic [RANGE_WIDTH-1:0]        range_t;

  localparam range_t NO_ECHO = '1;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    LISTEN,
    ADVANCE
  } scan_state_t;

endpackage

// File: rtl/beam_scan_scheduler_if.sv
// Control/datapath bundle of the beam-scan scheduler; the slave modport is the scheduler side.
interface beam_scan_scheduler_if;

  logic                  enable_in;
  logic                  fixed_mode_in;
  sonar_scan_pkg::angle_t fixed_angle_in;
  logic                  tof_valid_in;
  sonar_scan_pkg::range_t range_in;

  sonar_scan_pkg::angle_t beam_angle_out;
  logic                  burst_start_out;
  logic                  burst_active_out;
  logic                  listen_out;
  logic                  result_valid_out;
  sonar_scan_pkg::angle_t result_angle_out;
  sonar_scan_pkg::range_t result_range_out;
  logic                  frame_done_out;

  modport master (
    output enable_in, fixed_mode_in, fixed_angle_in, tof_valid_in, range_in,
    input  beam_angle_out, burst_start_out, burst_active_out, listen_out,
           result_valid_out, result_angle_out, result_range_out, frame_done_out
  );

  modport slave (
    input  enable_in, fixed_mode_in, fixed_angle_in, tof_valid_in, range_in,
    output beam_angle_out, burst_start_out, burst_active_out, listen_out,
           result_valid_out, result_angle_out, result_range_out, frame_done_out
  );

endinterface

// File: rtl/beam_scan_scheduler_angle_sequencer.sv
// Registered beam angle with next-angle clamp/wrap logic.
// SCAN_PINGPONG_EN: sweep bounces between the endpoints using a direction register.
module beam_scan_scheduler_angle_sequencer
  import sonar_scan_pkg::*;
#(
  parameter int ANGLE_MIN  = -30,
  parameter int ANGLE_MAX  = 30,
  parameter int ANGLE_STEP = 10
) (
  input  logic   clk_in,
  input  logic   rst_in,
  input  logic   advance,
  input  logic   fixed_mode,
  input  angle_t fixed_angle,
  output angle_t angle,
  output logic   frame_done
);

  typedef logic signed [ANGLE_WIDTH:0] wide_t;

  localparam wide_t MIN_W  = wide_t'(ANGLE_MIN);
  localparam wide_t MAX_W  = wide_t'(ANGLE_MAX);
  localparam wide_t STEP_W = wide_t'(ANGLE_STEP);

  angle_t angle_reg;
  wide_t  angle_w;
  wide_t  fixed_w;
  wide_t  up_w;
  wide_t  down_w;
  wide_t  next_w;

  assign angle_w = {angle_reg[ANGLE_WIDTH-1], angle_reg};
  assign fixed_w = {fixed_angle[ANGLE_WIDTH-1], fixed_angle};
  assign up_w    = angle_w + STEP_W;
  assign down_w  = angle_w - STEP_W;

`ifdef SCAN_PINGPONG_EN
  logic dir_up_reg;
  logic dir_up_next;

  always_comb begin
    next_w      = angle_w;
    dir_up_next = dir_up_reg;
    if (fixed_mode) begin
      if (fixed_w < MIN_W)      next_w = MIN_W;
      else if (fixed_w > MAX_W) next_w = MAX_W;
      else                      next_w = fixed_w;
    end else if (angle_w < MIN_W || angle_w > MAX_W) begin
      next_w      = MIN_W;
      dir_up_next = 1'b1;
    end else if (dir_up_reg) begin
      // Bounce off the top without repeating the endpoint.
      if (up_w > MAX_W) begin
        next_w      = down_w;
        dir_up_next = 1'b0;
      end else begin
        next_w = up_w;
      end
    end else begin
      if (down_w < MIN_W) begin
        next_w      = up_w;
        dir_up_next = 1'b1;
      end else begin
        next_w = down_w;
      end
    end
  end

  assign frame_done = !fixed_mode && (angle_w == MAX_W || angle_w == MIN_W);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      angle_reg  <= angle_t'(ANGLE_MIN);
      dir_up_reg <= 1'b1;
    end else if (advance) begin
      angle_reg  <= next_w[ANGLE_WIDTH-1:0];
      dir_up_reg <= dir_up_next;
    end
  end
`else
  always_comb begin
    next_w = angle_w;
    if (fixed_mode) begin
      if (fixed_w < MIN_W)      next_w = MIN_W;
      else if (fixed_w > MAX_W) next_w = MAX_W;
      else                      next_w = fixed_w;
    end else if (angle_w < MIN_W || angle_w > MAX_W || up_w > MAX_W) begin
      next_w = MIN_W;
    end else begin
      next_w = up_w;
    end
  end

  assign frame_done = !fixed_mode && (angle_w == MAX_W);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      angle_reg <= angle_t'(ANGLE_MIN);
    end else if (advance) begin
      angle_reg <= next_w[ANGLE_WIDTH-1:0];
    end
  end
`endif

  assign angle = angle_reg;

endmodule

// File: rtl/beam_scan_scheduler.sv
// Ping-period sequencer: burst window, listen window, first-echo capture and beam sweep.
// SCAN_PINGPONG_EN (in the angle sequencer) selects a bouncing sweep instead of wrapping.
module beam_scan_scheduler
  import sonar_scan_pkg::*;
#(
  parameter int PERIOD_CYCLES = 16777216,
  parameter int BURST_CYCLES  = 524288,
  parameter int ANGLE_MIN     = -30,
  parameter int ANGLE_MAX     = 30,
  parameter int ANGLE_STEP    = 10
) (
  input logic                  clk_in,
  input logic                  rst_in,
  beam_scan_scheduler_if.slave bus
);

  localparam int CNT_W         = $clog2(PERIOD_CYCLES);
  localparam int LISTEN_CYCLES = PERIOD_CYCLES - BURST_CYCLES - 1;
  localparam logic [CNT_W-1:0] BURST_LAST  = CNT_W'(BURST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LISTEN_LAST = CNT_W'(LISTEN_CYCLES - 1);

  scan_state_t      state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             burst_start_reg;
  logic             burst_active_reg;
  logic             listen_reg;
  logic             result_valid_reg;
  angle_t           result_angle_reg;
  range_t           result_range_reg;
  logic             frame_done_reg;
  logic             echo_seen_reg;
  range_t           echo_range_reg;

  logic   ping_end;
  logic   frame_done_next;
  angle_t beam_angle;
  range_t captured_range;

  assign ping_end = (state_reg == LISTEN) && (cnt_reg == LISTEN_LAST);

  // A strobe on the last listen cycle still counts as the first echo.
  assign captured_range = echo_seen_reg     ? echo_range_reg :
                          bus.tof_valid_in  ? bus.range_in   : NO_ECHO;

  beam_scan_scheduler_angle_sequencer #(
    .ANGLE_MIN  (ANGLE_MIN),
    .ANGLE_MAX  (ANGLE_MAX),
    .ANGLE_STEP (ANGLE_STEP)
  ) u_angle_sequencer (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .advance     (ping_end),
    .fixed_mode  (bus.fixed_mode_in),
    .fixed_angle (bus.fixed_angle_in),
    .angle       (beam_angle),
    .frame_done  (frame_done_next)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      burst_start_reg  <= 1'b0;
      burst_active_reg <= 1'b0;
      listen_reg       <= 1'b0;
      result_valid_reg <= 1'b0;
      result_angle_reg <= '0;
      result_range_reg <= '0;
      frame_done_reg   <= 1'b0;
      echo_seen_reg    <= 1'b0;
      echo_range_reg   <= '0;
    end else begin
      burst_start_reg  <= 1'b0;
      result_valid_reg <= 1'b0;
      frame_done_reg   <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (bus.enable_in) begin
            state_reg        <= BURST;
            cnt_reg          <= '0;
            burst_start_reg  <= 1'b1;
            burst_active_reg <= 1'b1;
          end
        end
        BURST: begin
          if (cnt_reg == BURST_LAST) begin
            state_reg        <= LISTEN;
            cnt_reg          <= '0;
            burst_active_reg <= 1'b0;
            listen_reg       <= 1'b1;
            echo_seen_reg    <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        LISTEN: begin
          if (bus.tof_valid_in && !echo_seen_reg) begin
            echo_seen_reg  <= 1'b1;
            echo_range_reg <= bus.range_in;
          end
          if (ping_end) begin
            state_reg        <= ADVANCE;
            cnt_reg          <= '0;
            listen_reg       <= 1'b0;
            result_valid_reg <= 1'b1;
            result_angle_reg <= beam_angle;
            result_range_reg <= captured_range;
            frame_done_reg   <= frame_done_next;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ADVANCE: begin
          if (bus.enable_in) begin
            state_reg        <= BURST;
            burst_start_reg  <= 1'b1;
            burst_active_reg <= 1'b1;
          end else begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.beam_angle_out   = beam_angle;
  assign bus.burst_start_out  = burst_start_reg;
  assign bus.burst_active_out = burst_active_reg;
  assign bus.listen_out       = listen_reg;
  assign bus.result_valid_out = result_valid_reg;
  assign bus.result_angle_out = result_angle_reg;
  assign bus.result_range_out = result_range_reg;
  assign bus.frame_done_out   = frame_done_reg;

endmodule

// File: tb/tb_beam_scan_scheduler.sv
// Bench for beam_scan_scheduler with a 100-cycle ping (20 burst) and a per-ping reference model.
module tb_beam_scan_scheduler;
  import sonar_scan_pkg::*;

  localparam int PERIOD = 100;
  localparam int BURST  = 20;
  localparam int AMIN   = -30;
  localparam int AMAX   = 30;
  localparam int ASTEP  = 10;
  localparam int LISTEN_FIRST = BURST + 1;
  localparam int LISTEN_LAST  = PERIOD - 1;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;

  beam_scan_scheduler_if bus();

  beam_scan_scheduler #(
    .PERIOD_CYCLES (PERIOD),
    .BURST_CYCLES  (BURST),
    .ANGLE_MIN     (AMIN),
    .ANGLE_MAX     (AMAX),
    .ANGLE_STEP    (ASTEP)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: current angle and sweep direction
  int model_angle;
  bit model_up;

  // Per-ping stimulus (cycle index within the ping, 1 = first burst cycle)
  int          strobe_k[$];
  logic [15:0] strobe_r[$];

  // Observations collected by do_ping
  logic obs_valid, obs_frame, obs_start, obs_active, obs_stable;
  int   obs_angle, obs_first_angle, obs_next_angle, obs_extra;
  logic [15:0] obs_range;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic void model_reset();
    model_angle = AMIN;
    model_up    = 1'b1;
  endfunction

  // Returns the angle the ping belonged to and whether it closes a sweep, then moves on.
  function automatic void model_step(input bit fixed, input int fa,
                                     output int done_angle, output bit done_frame);
    int step;
    done_angle = model_angle;
`ifdef SCAN_PINGPONG_EN
    done_frame = !fixed && (model_angle == AMAX || model_angle == AMIN);
`else
    done_frame = !fixed && (model_angle == AMAX);
`endif
    if (fixed) begin
      model_angle = (fa < AMIN) ? AMIN : (fa > AMAX) ? AMAX : fa;
    end else if (model_angle < AMIN || model_angle > AMAX) begin
      model_angle = AMIN;
      model_up    = 1'b1;
    end else begin
`ifdef SCAN_PINGPONG_EN
      step = model_up ? ASTEP : -ASTEP;
      if (model_angle + step > AMAX || model_angle + step < AMIN) begin
        model_up = !model_up;
        step     = -step;
      end
      model_angle = model_angle + step;
`else
      step = ASTEP;
      model_angle = (model_angle + step > AMAX) ? AMIN : model_angle + step;
`endif
    end
  endfunction

  // First strobe inside the listen window wins; otherwise the no-echo marker.
  function automatic logic [15:0] model_range();
    int best = 1 << 20;
    logic [15:0] r = 16'hFFFF;
    foreach (strobe_k[i])
      if (strobe_k[i] >= LISTEN_FIRST && strobe_k[i] <= LISTEN_LAST && strobe_k[i] <= best) begin
        best = strobe_k[i];
        r    = strobe_r[i];
      end
    return r;
  endfunction

  // Starts on cycle 1 of a ping (burst_start visible), ends on the cycle after ADVANCE.
  task automatic do_ping(input int drop_k);
    obs_first_angle = int'(bus.beam_angle_out);
    obs_stable = 1'b1;
    obs_extra  = 0;
    obs_valid  = 1'b0;
    obs_frame  = 1'b0;
    obs_angle  = 0;
    obs_range  = 16'h0;
    for (int k = 1; k <= PERIOD; k++) begin
      if (k < PERIOD && int'(bus.beam_angle_out) != obs_first_angle) obs_stable = 1'b0;
      if (k == PERIOD) begin
        obs_valid = bus.result_valid_out;
        obs_angle = int'(bus.result_angle_out);
        obs_range = bus.result_range_out;
        obs_frame = bus.frame_done_out;
      end else if (bus.result_valid_out) begin
        obs_extra++;
      end
      bus.tof_valid_in = 1'b0;
      bus.range_in     = 16'($urandom);
      foreach (strobe_k[i])
        if (strobe_k[i] == k) begin
          bus.tof_valid_in = 1'b1;
          bus.range_in     = strobe_r[i];
        end
      if (drop_k > 0 && k >= drop_k) bus.enable_in = 1'b0;
      tick();
    end
    bus.tof_valid_in = 1'b0;
    obs_start      = bus.burst_start_out;
    obs_active     = bus.burst_active_out;
    obs_next_angle = int'(bus.beam_angle_out);
    $display("ping: angle=%0d range=%h valid=%b frame=%b next_angle=%0d",
             obs_angle, obs_range, obs_valid, obs_frame, obs_next_angle);
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({bus.burst_start_out, bus.burst_active_out, bus.listen_out, bus.result_valid_out,
         bus.frame_done_out} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_strobes: got %b expected 00000",
               {bus.burst_start_out, bus.burst_active_out, bus.listen_out,
                bus.result_valid_out, bus.frame_done_out});
    end
    n_cmp++;
    if (int'(bus.beam_angle_out) != AMIN || bus.result_angle_out !== 8'sd0 ||
        bus.result_range_out !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_values: angle=%0d res_angle=%0d res_range=%h expected %0d 0 0000",
               bus.beam_angle_out, bus.result_angle_out, bus.result_range_out, AMIN);
    end
    rst_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if (bus.burst_active_out !== 1'b0 || bus.listen_out !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_quiet: burst_active=%b listen=%b expected 0 0",
               bus.burst_active_out, bus.listen_out);
    end
    $display("reset: angle=%0d", bus.beam_angle_out);
  endtask

  task automatic test_timing();
    int n_start = 0, first_start = 0, last_start = 0;
    int n_active = 0, n_listen = 0, first_listen = 0, first_valid = 0;
    int exp_angle;
    bit exp_frame;
    logic [15:0] res_range = 16'h0;
    int res_angle = 0;
    bus.enable_in = 1'b1;
    for (int k = 1; k <= PERIOD + 1; k++) begin
      tick();
      if (bus.burst_start_out) begin
        n_start++;
        if (first_start == 0) first_start = k;
        last_start = k;
      end
      if (k <= PERIOD && bus.burst_active_out) n_active++;
      if (bus.listen_out) begin
        n_listen++;
        if (first_listen == 0) first_listen = k;
      end
      if (bus.result_valid_out && first_valid == 0) begin
        first_valid = k;
        res_angle   = int'(bus.result_angle_out);
        res_range   = bus.result_range_out;
      end
    end
    model_step(1'b0, 0, exp_angle, exp_frame);
    n_cmp++;
    if (n_start != 2 || first_start != 1 || last_start != PERIOD + 1) begin
      n_bad++;
      $display("FAIL timing_start: got count=%0d first=%0d last=%0d expected 2 1 %0d",
               n_start, first_start, last_start, PERIOD + 1);
    end
    n_cmp++;
    if (n_active != BURST) begin
      n_bad++;
      $display("FAIL timing_burst_len: got %0d expected %0d", n_active, BURST);
    end
    n_cmp++;
    if (n_listen != PERIOD - BURST - 1 || first_listen != LISTEN_FIRST) begin
      n_bad++;
      $display("FAIL timing_listen: got len=%0d first=%0d expected %0d %0d",
               n_listen, first_listen, PERIOD - BURST - 1, LISTEN_FIRST);
    end
    n_cmp++;
    if (first_valid != PERIOD) begin
      n_bad++;
      $display("FAIL timing_result_cycle: got %0d expected %0d", first_valid, PERIOD);
    end
    n_cmp++;
    if (res_angle != exp_angle || res_range !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL timing_result: got angle=%0d range=%h expected %0d ffff",
               res_angle, res_range, exp_angle);
    end
    $display("timing: start=%0d burst=%0d listen=%0d result@%0d", first_start, n_active, n_listen,
             first_valid);
  endtask

  task automatic test_sweep();
    int exp_angle;
    bit exp_frame;
    int n_frames = 0;
    strobe_k.delete(); strobe_r.delete();
    strobe_k.push_back(LISTEN_FIRST + 10); strobe_r.push_back(16'h0123);
    for (int p = 0; p < 8; p++) begin
      do_ping(0);
      model_step(1'b0, 0, exp_angle, exp_frame);
      if (obs_frame) n_frames++;
      n_cmp++;
      if (obs_valid !== 1'b1 || obs_angle != exp_angle || obs_range !== 16'h0123) begin
        n_bad++;
        $display("FAIL sweep_result: got v=%b angle=%0d range=%h expected 1 %0d 0123",
                 obs_valid, obs_angle, obs_range, exp_angle);
      end
      n_cmp++;
      if (obs_frame !== exp_frame) begin
        n_bad++;
        $display("FAIL sweep_frame: got %b expected %b at angle %0d", obs_frame, exp_frame, exp_angle);
      end
      n_cmp++;
      if (!obs_stable || obs_first_angle != exp_angle || obs_next_angle != model_angle ||
          obs_start !== 1'b1 || obs_extra != 0) begin
        n_bad++;
        $display("FAIL sweep_angle: got stable=%b first=%0d next=%0d start=%b extra=%0d expected 1 %0d %0d 1 0",
                 obs_stable, obs_first_angle, obs_next_angle, obs_start, obs_extra, exp_angle,
                 model_angle);
      end
    end
    n_cmp++;
    if (n_frames < 1) begin
      n_bad++;
      $display("FAIL sweep_frame_count: got %0d expected at least 1", n_frames);
    end
  endtask

  task automatic test_no_echo();
    int exp_angle;
    bit exp_frame;
    for (int c = 0; c < 4; c++) begin
      strobe_k.delete(); strobe_r.delete();
      case (c)
        1: begin
          strobe_k.push_back(5);      strobe_r.push_back(16'h0AAA);
          strobe_k.push_back(BURST);  strobe_r.push_back(16'h0BBB);
          strobe_k.push_back(PERIOD); strobe_r.push_back(16'h0CCC);
        end
        2: begin
          strobe_k.push_back(BURST);       strobe_r.push_back(16'h1111);
          strobe_k.push_back(LISTEN_LAST); strobe_r.push_back(16'h0BEE);
        end
        3: begin
          strobe_k.push_back(LISTEN_FIRST); strobe_r.push_back(16'h0A0A);
          strobe_k.push_back(LISTEN_LAST);  strobe_r.push_back(16'h0B0B);
        end
        default: ;
      endcase
      do_ping(0);
      model_step(1'b0, 0, exp_angle, exp_frame);
      n_cmp++;
      if (obs_valid !== 1'b1 || obs_range !== model_range() || obs_angle != exp_angle) begin
        n_bad++;
        $display("FAIL no_echo_case%0d: got v=%b range=%h angle=%0d expected 1 %h %0d",
                 c, obs_valid, obs_range, obs_angle, model_range(), exp_angle);
      end
    end
  endtask

  task automatic test_two_strobes();
    int exp_angle;
    bit exp_frame;
    strobe_k.delete(); strobe_r.delete();
    strobe_k.push_back(40); strobe_r.push_back(16'h0050);
    strobe_k.push_back(60); strobe_r.push_back(16'h0090);
    do_ping(0);
    model_step(1'b0, 0, exp_angle, exp_frame);
    n_cmp++;
    if (obs_range !== 16'h0050 || obs_angle != exp_angle) begin
      n_bad++;
      $display("FAIL two_strobes: got range=%h angle=%0d expected 0050 %0d",
               obs_range, obs_angle, exp_angle);
    end
  endtask

  task automatic test_fixed_mode();
    int fa_tab[4] = '{45, -100, 7, 0};
    bit fx_tab[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int exp_angle;
    bit exp_frame;
    int fa;
    strobe_k.delete(); strobe_r.delete();
    for (int c = 0; c < 4; c++) begin
      fa = fa_tab[c];
      bus.fixed_mode_in  = fx_tab[c];
      bus.fixed_angle_in = fa[7:0];
      do_ping(0);
      model_step(fx_tab[c], fa, exp_angle, exp_frame);
      n_cmp++;
      if (obs_angle != exp_angle || obs_next_angle != model_angle || obs_frame !== exp_frame) begin
        n_bad++;
        $display("FAIL fixed_case%0d: got angle=%0d next=%0d frame=%b expected %0d %0d %b",
                 c, obs_angle, obs_next_angle, obs_frame, exp_angle, model_angle, exp_frame);
      end
    end
    bus.fixed_mode_in = 1'b0;
  endtask

  task automatic test_random();
    int exp_angle;
    bit exp_frame;
    int fa;
    bit fx;
    int ns;
    for (int p = 0; p < 20; p++) begin
      strobe_k.delete(); strobe_r.delete();
      ns = int'($urandom_range(0, 3));
      for (int i = 0; i < ns; i++) begin
        strobe_k.push_back(int'($urandom_range(1, PERIOD)));
        strobe_r.push_back(16'($urandom_range(0, 16'hFFFE)));
      end
      fx = ($urandom_range(0, 3) == 0);
      fa = int'($urandom_range(0, 255)) - 128;
      bus.fixed_mode_in  = fx;
      bus.fixed_angle_in = fa[7:0];
      do_ping(0);
      model_step(fx, fa, exp_angle, exp_frame);
      n_cmp++;
      if (obs_valid !== 1'b1 || obs_angle != exp_angle || obs_range !== model_range() ||
          obs_frame !== exp_frame || obs_next_angle != model_angle || !obs_stable) begin
        n_bad++;
        $display("FAIL random_ping%0d: got v=%b a=%0d r=%h f=%b next=%0d stable=%b expected 1 %0d %h %b %0d 1",
                 p, obs_valid, obs_angle, obs_range, obs_frame, obs_next_angle, obs_stable,
                 exp_angle, model_range(), exp_frame, model_angle);
      end
    end
    bus.fixed_mode_in = 1'b0;
  endtask

  task automatic test_enable_drop();
    int exp_angle;
    bit exp_frame;
    bit idle_ok = 1'b1;
    strobe_k.delete(); strobe_r.delete();
    do_ping(50);
    model_step(1'b0, 0, exp_angle, exp_frame);
    n_cmp++;
    if (obs_valid !== 1'b1 || obs_angle != exp_angle || obs_start !== 1'b0 || obs_active !== 1'b0) begin
      n_bad++;
      $display("FAIL enable_drop: got v=%b angle=%0d start=%b active=%b expected 1 %0d 0 0",
               obs_valid, obs_angle, obs_start, obs_active, exp_angle);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.burst_active_out || bus.listen_out || int'(bus.beam_angle_out) != model_angle)
        idle_ok = 1'b0;
    end
    n_cmp++;
    if (!idle_ok) begin
      n_bad++;
      $display("FAIL idle_hold: got angle=%0d active=%b listen=%b expected %0d 0 0",
               bus.beam_angle_out, bus.burst_active_out, bus.listen_out, model_angle);
    end
    bus.enable_in = 1'b1;
    tick();
    n_cmp++;
    if (bus.burst_start_out !== 1'b1) begin
      n_bad++;
      $display("FAIL reenable_start: got %b expected 1", bus.burst_start_out);
    end
    $display("enable_drop: held angle=%0d", bus.beam_angle_out);
  endtask

  task automatic test_reset_mid_burst();
    int exp_angle;
    bit exp_frame;
    for (int i = 1; i < 10; i++) tick();
    rst_in = 1'b0;
    #1;
    n_cmp++;
    if ({bus.burst_start_out, bus.burst_active_out, bus.listen_out, bus.result_valid_out,
         bus.frame_done_out} !== 5'b0 || int'(bus.beam_angle_out) != AMIN ||
        bus.result_range_out !== 16'h0 || bus.result_angle_out !== 8'sd0) begin
      n_bad++;
      $display("FAIL async_reset: got active=%b angle=%0d range=%h expected 0 %0d 0000",
               bus.burst_active_out, bus.beam_angle_out, bus.result_range_out, AMIN);
    end
    model_reset();
    tick();
    tick();
    rst_in = 1'b1;
    tick();
    n_cmp++;
    if (bus.burst_start_out !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_start: got %b expected 1", bus.burst_start_out);
    end
    strobe_k.delete(); strobe_r.delete();
    strobe_k.push_back(70); strobe_r.push_back(16'h4321);
    do_ping(0);
    model_step(1'b0, 0, exp_angle, exp_frame);
    n_cmp++;
    if (obs_angle != exp_angle || obs_range !== 16'h4321 || obs_next_angle != model_angle) begin
      n_bad++;
      $display("FAIL restart_ping: got angle=%0d range=%h next=%0d expected %0d 4321 %0d",
               obs_angle, obs_range, obs_next_angle, exp_angle, model_angle);
    end
  endtask

  initial begin
    bus.enable_in      = 1'b0;
    bus.fixed_mode_in  = 1'b0;
    bus.fixed_angle_in = '0;
    bus.tof_valid_in   = 1'b0;
    bus.range_in       = '0;
    model_reset();
    test_reset();
    test_timing();
    test_sweep();
    test_no_echo();
    test_two_strobes();
    test_fixed_mode();
    test_random();
    test_enable_drop();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
